// File: rtl/spi_ram_ctrl.sv
// Command-decoding 8-bit RAM fed by 10-bit SPI slave words. Exactly one command runs per rx_valid high period.
// Latency: tx_data/tx_valid and seq_err register 1 cycle after the accept cycle. tx_valid is then held for TX_HOLD cycles.
// Backpressure: none. Every word is accepted, and a command that arrives out of sequence is rejected with a seq_err pulse.
module spi_ram_ctrl #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int TX_HOLD   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   output logic       seq_err
);
   localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int CW = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
   localparam logic [ADDR_SIZE:0] DEPTH     = (ADDR_SIZE + 1)'(MEM_DEPTH);
   localparam logic [CW-1:0]      HOLD_LAST = CW'(TX_HOLD - 1);

   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

   logic [7:0]           mem [MEM_DEPTH];
   logic                 rx_valid_q;
   logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
   logic                 wr_addr_vld, rd_addr_vld;
   tx_state_t            state, state_nxt;
   logic [CW-1:0]        hold_cnt, hold_cnt_nxt;
   logic [7:0]           tx_data_nxt;
   logic                 acc;
   logic [1:0]           cmd;
   logic [7:0]           pay;
   logic                 wr_ok, wr_en, rd_go, err_nxt;
   logic [7:0]           rd_word;

   assign acc     = rx_valid & ~rx_valid_q;
   assign cmd     = rx_data[9:8];
   assign pay     = rx_data[7:0];
   assign wr_ok   = wr_addr_vld && ({1'b0, wr_addr} < DEPTH);
   assign wr_en   = acc && (cmd == 2'b01) && wr_ok;
   assign rd_go   = acc && (cmd == 2'b11) && rd_addr_vld;
   assign err_nxt = acc && (((cmd == 2'b01) && !wr_ok) || ((cmd == 2'b11) && !rd_addr_vld));
   // Addresses past the populated depth read back as zero rather than aliasing.
   assign rd_word = ({1'b0, rd_addr} < DEPTH) ? mem[rd_addr[IW-1:0]] : 8'h00;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr[IW-1:0]] <= pay;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_valid_q  <= 1'b0;
         seq_err     <= 1'b0;
         wr_addr     <= '0;
         rd_addr     <= '0;
         wr_addr_vld <= 1'b0;
         rd_addr_vld <= 1'b0;
      end else begin
         rx_valid_q <= rx_valid;
         seq_err    <= err_nxt;
         if (acc && (cmd == 2'b00)) begin
            wr_addr     <= pay[ADDR_SIZE-1:0];
            wr_addr_vld <= 1'b1;
         end
         // A successful read consumes its address.
         if (acc && (cmd == 2'b10)) begin
            rd_addr     <= pay[ADDR_SIZE-1:0];
            rd_addr_vld <= 1'b1;
         end else if (rd_go) begin
            rd_addr_vld <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= TX_IDLE;
         hold_cnt <= '0;
         tx_data  <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
         tx_data  <= tx_data_nxt;
      end
   end

   // A new read restarts the hold window, even while a hold is already running.
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      tx_data_nxt  = tx_data;
      if (rd_go) begin
         state_nxt    = TX_SEND;
         hold_cnt_nxt = HOLD_LAST;
         tx_data_nxt  = rd_word;
      end else if (state == TX_SEND) begin
         if (hold_cnt == '0) state_nxt = TX_IDLE;
         else                hold_cnt_nxt = hold_cnt - CW'(1);
      end
   end

   assign tx_valid = (state == TX_SEND);

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Single-port synchronous RAM with command decode. It sits directly downstream of the SPI slave and consumes its 10-bit rx_data words. It returns read data on an 8-bit bus with tx_valid, which the slave shifts out on MISO. rx_data[9:8] carries the command and rx_data[7:0] carries the address or data payload.

Parameters:
MEM_DEPTH, 256, number of 8-bit words; must be ≤ 2**ADDR_SIZE.
ADDR_SIZE, 8, address width taken from payload[ADDR_SIZE-1:0]; must be ≤ 8.
TX_HOLD, 8, number of cycles tx_valid stays high per read.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
rx_data  in  10  [9:8] command, [7:0] payload.
rx_valid  in  1  word valid; may stay high for several cycles per word.
tx_data  out  8  read data to the SPI slave.
tx_valid  out  1  tx_data valid, held for TX_HOLD cycles.
seq_err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - tx_data = 0, tx_valid = 0, seq_err = 0.
  - wr_addr = 0, rd_addr = 0; wr_addr_vld = 0, rd_addr_vld = 0; hold counter = 0.
  - Memory contents are NOT reset.
- Accept strobe:
  - acc = rx_valid & ~rx_valid_q, where rx_valid_q is a registered copy of rx_valid (reset 0).
  - Exactly one command is executed per rx_valid high period, regardless of pulse length.
- Command decode, on the acc cycle, using the payload p = rx_data[7:0]:
  - 2'b00 write-address: wr_addr <= p[ADDR_SIZE-1:0]; wr_addr_vld <= 1.
  - 2'b01 write-data:
    - If wr_addr_vld and wr_addr < MEM_DEPTH: mem[wr_addr] <= p.
    - Else: no write; seq_err = 1 for the next cycle.
    - wr_addr and wr_addr_vld are retained, so consecutive data words rewrite the same address.
  - 2'b10 read-address: rd_addr <= p[ADDR_SIZE-1:0]; rd_addr_vld <= 1.
  - 2'b11 read-data:
    - If rd_addr_vld: tx_data <= (rd_addr < MEM_DEPTH) ? mem[rd_addr] : 8'h00; tx_valid <= 1; hold counter <= TX_HOLD-1; rd_addr_vld <= 0 (each read needs a fresh address).
    - If not rd_addr_vld: seq_err pulse; tx_data and tx_valid unchanged.
    - The payload of a read-data command is ignored.
- Latency:
  - A write is visible to a read-data accepted on the following cycle or later.
  - tx_data and tx_valid are registered and appear 1 cycle after acc.
- TX hold state machine, two states:
  - TX_IDLE: tx_valid = 0; a valid read-data command moves to TX_SEND.
  - TX_SEND: tx_valid = 1; the counter decrements each cycle; when the counter is 0, go to TX_IDLE next cycle. This gives exactly TX_HOLD cycles high.
  - tx_data is stable throughout TX_SEND and keeps its last value after it.
- Simultaneous events:
  - A valid read-data accepted during TX_SEND reloads tx_data and the counter and stays in TX_SEND.
  - Other commands during TX_SEND execute normally and do not affect tx_valid or tx_data.
  - A write-data to rd_addr during TX_SEND does not change the already-latched tx_data.
- seq_err is registered: high for exactly 1 cycle after the offending acc; two back-to-back errors give two pulses.
- Reset mid-operation:
  - tx_valid drops immediately (asynchronous) and both address valid flags clear.
  - The next write-data or read-data must be preceded by an address command, or it errors.
  - A rx_valid already high when reset releases counts as a new word on the first clock after release.

Test Plan:
- Basic write/read: cmd 00/0x12 → 01/0xA5 → 10/0x12 → 11/xx → tx_data=0xA5 one cycle after the 4th acc; tx_valid high exactly 8 cycles; seq_err never asserts.
- Long strobe: rx_valid held 5 cycles with 01/0x3C after 00/0x07 → exactly one write. Rewrite with 01/0x55 held 1 cycle, then read 0x07 → 0x55. Confirms one execution per rx_valid period.
- Sequence errors: after reset, issue 01/0xFF → seq_err pulse, memory unchanged. Issue 11 with no prior 10 → seq_err pulse, tx_valid stays 0. Issue a second 11 after one valid read → seq_err pulse.
- Reload during hold: read addr 1 (data 0x11); on hold cycle 3 accept 10/0x02 then 11 (data 0x22) → tx_data=0x22, tx_valid stays continuously high until 8 cycles after the second read acc.
- Out-of-range, with MEM_DEPTH=16: write to 0x20 → seq_err pulse, no write. Read 0x20 → tx_data=0x00 with tx_valid high.
- Async reset mid-hold: assert rst_n low between clock edges during TX_SEND → tx_valid=0 immediately. After release, 11 → seq_err pulse.
